iob_cache_be_arbiter: RTL and testbench

- Round-robin arbiter sharing one IOb-native back-end memory port (e.g. the simulation single-port RAM behind iob_cache_iob) among N_MASTERS cache back-ends (I-cache, D-cache, DMA).
- Masters connect to the slave side; the single master port drives the memory.
- One outstanding transaction at a time; read responses are routed back to the issuing master.

---
 rtl/iob_cache_be_arbiter_pkg.sv | 22 ++
 rtl/iob_cache_be_arbiter_if.sv | 39 +++
 rtl/iob_cache_be_arbiter_rr_prio.sv | 35 +++
 rtl/iob_cache_be_arbiter.sv | 131 +++++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the cache back-end arbiter.
//   arb_state_e : arbiter FSM state encoding
//   rr_ptr_w()  : width of a master index / round-robin pointer
//   next_ptr()  : wrap-around increment that works for any master count
package iob_cache_be_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        WAIT_R = 2'd2
    } arb_state_e;

    function automatic int rr_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit compare rather than truncation so that N=3,5,6,7 wrap to 0.
    function automatic int next_ptr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/iob_cache_be_arbiter_if.sv
// Bus bundle between the cache back-ends, the arbiter and the memory port.
//   m_*  : per-master request side (packed, master k at slice k)
//   be_* : single IOb-native back-end port towards the memory
//   slave  modport : arbiter view
//   master modport : environment view (masters + memory)
interface iob_cache_be_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]            m_valid_i;
    logic [N_MASTERS*ADDR_W-1:0]     m_addr_i;
    logic [N_MASTERS*DATA_W-1:0]     m_wdata_i;
    logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i;
    logic [N_MASTERS-1:0]            m_ready_o;
    logic [DATA_W-1:0]               m_rdata_o;
    logic [N_MASTERS-1:0]            m_rvalid_o;
    logic                            be_valid_o;
    logic [ADDR_W-1:0]               be_addr_o;
    logic [DATA_W-1:0]               be_wdata_o;
    logic [DATA_W/8-1:0]             be_wstrb_o;
    logic [DATA_W-1:0]               be_rdata_i;
    logic                            be_rvalid_i;
    logic                            be_ready_i;

    modport slave (
        input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  be_rdata_i, be_rvalid_i, be_ready_i,
        output m_ready_o, m_rdata_o, m_rvalid_o,
        output be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );

    modport master (
        output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output be_rdata_i, be_rvalid_i, be_ready_i,
        input  m_ready_o, m_rdata_o, m_rvalid_o,
        input  be_valid_o, be_addr_o, be_wdata_o, be_wstrb_o
    );
endinterface

// File: rtl/iob_cache_be_arbiter_rr_prio.sv
// Combinational round-robin priority encoder.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   sel_o   : first requesting index at or after ptr_i (wrapping)
//   found_o : at least one request present
module iob_cache_rr_prio #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] sel_o,
    output logic             found_o
);

    int               idx;
    logic [PTR_W-1:0] idx_p;

    always_comb begin
        sel_o   = '0;
        found_o = 1'b0;
        idx     = 0;
        idx_p   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            idx_p = PTR_W'(idx);
            if (!found_o && req_i[idx_p]) begin
                found_o = 1'b1;
                sel_o   = idx_p;
            end
        end
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one back-end memory port among N_MASTERS
// cache back-ends, with one outstanding transaction at a time.
//   clk_i    : clock
//   arst_n_i : asynchronous active-low reset
//   cke_i    : clock enable, freezes all state when low
//   bus      : masters + back-end signals (slave modport)
//
// state  | meaning
// IDLE   | no grant held; selected master muxed straight through
// HOLD   | request presented but not accepted; grant locked to owner
// WAIT_R | read accepted; waiting for be_rvalid_i for owner
module iob_cache_be_arbiter
    import iob_cache_be_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32
) (
    input logic                   clk_i,
    input logic                   arst_n_i,
    input logic                   cke_i,
    iob_cache_be_arbiter_if.slave bus
);

    localparam int RR_PTR_W = rr_ptr_w(N_MASTERS);
    localparam int STRB_W   = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic [RR_PTR_W-1:0] owner_q, owner_d;
    logic [RR_PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [RR_PTR_W-1:0] sel;
    logic [RR_PTR_W-1:0] cur;
    logic                found;
    logic                active;
    logic                is_write;
    logic [STRB_W-1:0]   cur_strb;

    iob_cache_rr_prio #(
        .N     (N_MASTERS),
        .PTR_W (RR_PTR_W)
    ) u_rr_prio (
        .req_i   (bus.m_valid_i),
        .ptr_i   (rr_ptr_q),
        .sel_o   (sel),
        .found_o (found)
    );

    // Outputs are gated by the reset input so they are quiet while reset is
    // held even if masters keep their valids high.
    always_comb begin
        cur = (state_q == HOLD) ? owner_q : sel;
        case (state_q)
            IDLE:    active = found;
            HOLD:    active = bus.m_valid_i[owner_q];
            default: active = 1'b0;
        endcase
        active   = active & arst_n_i;
        cur_strb = bus.m_wstrb_i[cur*STRB_W +: STRB_W];
        is_write = |cur_strb;

        bus.be_valid_o = active;
        bus.be_addr_o  = active ? bus.m_addr_i[cur*ADDR_W +: ADDR_W] : '0;
        bus.be_wdata_o = active ? bus.m_wdata_i[cur*DATA_W +: DATA_W] : '0;
        bus.be_wstrb_o = active ? cur_strb : '0;

        bus.m_ready_o = '0;
        if (active && bus.be_ready_i) bus.m_ready_o[cur] = 1'b1;

        bus.m_rvalid_o = '0;
        if (arst_n_i && state_q == WAIT_R && bus.be_rvalid_i)
            bus.m_rvalid_o[owner_q] = 1'b1;

        bus.m_rdata_o = bus.be_rdata_i;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = sel;
                    if (bus.be_ready_i) begin
                        if (is_write)
                            rr_ptr_d = RR_PTR_W'(next_ptr(int'(sel), N_MASTERS));
                        else
                            state_d = WAIT_R;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Owner withdrawing its request releases the lock without
                // moving the priority pointer.
                if (!bus.m_valid_i[owner_q]) begin
                    state_d = IDLE;
                end else if (bus.be_ready_i) begin
                    if (is_write) begin
                        state_d  = IDLE;
                        rr_ptr_d = RR_PTR_W'(next_ptr(int'(owner_q), N_MASTERS));
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (bus.be_rvalid_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = RR_PTR_W'(next_ptr(int'(owner_q), N_MASTERS));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_iob_cache_be_arbiter.sv
// Self-checking bench for iob_cache_be_arbiter: directed scenarios on a
// 2-master and a 3-master instance, then randomized traffic on the
// 2-master instance against a transaction-level reference model.
module tb_iob_cache_be_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cke   = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state: master holding a locked grant, master waiting
    // for read data, and the master that has first priority next.
    int lock_m;
    int rd_m;
    int nxt;

    always #5 clk = ~clk;

    iob_cache_be_arbiter_if #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) b2 ();
    iob_cache_be_arbiter_if #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) b3 ();

    iob_cache_be_arbiter #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .cke_i    (cke),
        .bus      (b2.slave)
    );

    iob_cache_be_arbiter #(.N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .cke_i    (cke),
        .bus      (b3.slave)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        b2.m_valid_i = '0; b2.m_addr_i = '0; b2.m_wdata_i = '0; b2.m_wstrb_i = '0;
        b2.be_ready_i = 1'b0; b2.be_rvalid_i = 1'b0; b2.be_rdata_i = '0;
        b3.m_valid_i = '0; b3.m_addr_i = '0; b3.m_wdata_i = '0; b3.m_wstrb_i = '0;
        b3.be_ready_i = 1'b0; b3.be_rvalid_i = 1'b0; b3.be_rdata_i = '0;
    endtask

    task automatic set_m2(input int k, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        b2.m_valid_i[k]         = v;
        b2.m_addr_i[k*AW +: AW]  = a;
        b2.m_wdata_i[k*DW +: DW] = d;
        b2.m_wstrb_i[k*SW +: SW] = s;
    endtask

    task automatic set_m3(input int k, input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
        b3.m_valid_i[k]         = v;
        b3.m_addr_i[k*AW +: AW]  = a;
        b3.m_wdata_i[k*DW +: DW] = d;
        b3.m_wstrb_i[k*SW +: SW] = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cke   = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        lock_m = -1;
        rd_m   = -1;
        nxt    = 0;
    endtask

    function automatic int pick(input logic [1:0] v, input int start);
        for (int k = 0; k < 2; k++) begin
            int m;
            m = (start + k) % 2;
            if (((v >> m) & 2'b01) != 2'b00) return m;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        set_m2(0, 1'b1, 24'h40, 32'h1, 4'hF);
        set_m2(1, 1'b1, 24'h44, 32'h2, 4'h0);
        b2.be_ready_i = 1'b1; b2.be_rvalid_i = 1'b1;
        b3.m_valid_i = 3'b111; b3.be_ready_i = 1'b1;
        @(posedge clk); #2;
        checks++; if (b2.be_valid_o !== 1'b0) begin errors++; $display("FAIL reset_be_valid: got %b want 0", b2.be_valid_o); end
        checks++; if (b2.m_ready_o !== 2'b00) begin errors++; $display("FAIL reset_m_ready: got %b want 00", b2.m_ready_o); end
        checks++; if (b2.m_rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_m_rvalid: got %b want 00", b2.m_rvalid_o); end
        checks++; if (b2.be_wstrb_o !== 4'h0) begin errors++; $display("FAIL reset_be_wstrb: got %h want 0", b2.be_wstrb_o); end
        checks++; if (b3.be_valid_o !== 1'b0 || b3.m_ready_o !== 3'b000) begin
            errors++; $display("FAIL reset_n3: be_valid %b m_ready %b want 0/000", b3.be_valid_o, b3.m_ready_o); end
        do_reset();
    endtask

    task automatic test_single_write_read();
        logic [DW-1:0] mem_val;
        do_reset();
        set_m2(0, 1'b1, 24'h10, 32'hDEADBEEF, 4'hF);
        b2.be_ready_i = 1'b1;
        mem_val = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (b2.m_ready_o !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", b2.m_ready_o); end
        checks++; if (b2.be_addr_o !== 24'h10 || b2.be_wdata_o !== 32'hDEADBEEF || b2.be_wstrb_o !== 4'hF) begin
            errors++; $display("FAIL wr_bus: addr %h data %h strb %h want 10/deadbeef/f", b2.be_addr_o, b2.be_wdata_o, b2.be_wstrb_o); end
        @(posedge clk); #1;
        set_m2(0, 1'b1, 24'h10, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (b2.m_ready_o !== 2'b01 || b2.be_wstrb_o !== 4'h0) begin
            errors++; $display("FAIL rd_req: ready %b strb %h want 01/0", b2.m_ready_o, b2.be_wstrb_o); end
        @(posedge clk); #1;
        set_m2(0, 1'b0, 24'h0, 32'h0, 4'h0);
        b2.be_rvalid_i = 1'b1; b2.be_rdata_i = mem_val;
        @(negedge clk);
        checks++; if (b2.m_rvalid_o !== 2'b01) begin errors++; $display("FAIL rd_rvalid: got %b want 01", b2.m_rvalid_o); end
        checks++; if (b2.m_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", b2.m_rdata_o); end
        @(posedge clk); #1;
        b2.be_rvalid_i = 1'b0;
    endtask

    task automatic test_alternating_reads();
        logic [DW-1:0] rd;
        int exp;
        do_reset();
        set_m2(0, 1'b1, 24'h20, 32'h0, 4'h0);
        set_m2(1, 1'b1, 24'h24, 32'h0, 4'h0);
        b2.be_ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp = t % 2;
            @(negedge clk);
            checks++; if (b2.m_ready_o !== 2'(1 << exp) || b2.be_addr_o !== ((exp == 1) ? 24'h24 : 24'h20)) begin
                errors++; $display("FAIL alt_grant[%0d]: ready %b addr %h want master %0d", t, b2.m_ready_o, b2.be_addr_o, exp); end
            @(posedge clk); #1;
            rd = $urandom;
            b2.be_rvalid_i = 1'b1; b2.be_rdata_i = rd;
            @(negedge clk);
            checks++; if (b2.m_rvalid_o !== 2'(1 << exp) || b2.m_ready_o !== 2'b00 || b2.m_rdata_o !== rd) begin
                errors++; $display("FAIL alt_rvalid[%0d]: rvalid %b ready %b rdata %h want %b/00/%h", t, b2.m_rvalid_o, b2.m_ready_o, b2.m_rdata_o, 2'(1 << exp), rd); end
            @(posedge clk); #1;
            b2.be_rvalid_i = 1'b0;
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_m2(1, 1'b1, 24'h100, 32'h11111111, 4'hF);
        b2.be_ready_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++; if (b2.be_valid_o !== 1'b1 || b2.be_addr_o !== 24'h100 || b2.m_ready_o !== 2'b00) begin
                errors++; $display("FAIL hold[%0d]: valid %b addr %h ready %b want 1/100/00", t, b2.be_valid_o, b2.be_addr_o, b2.m_ready_o); end
            @(posedge clk); #1;
            if (t == 0) set_m2(0, 1'b1, 24'h200, 32'h22222222, 4'hF);
        end
        b2.be_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (b2.m_ready_o !== 2'b10 || b2.be_addr_o !== 24'h100) begin
            errors++; $display("FAIL hold_release: ready %b addr %h want 10/100", b2.m_ready_o, b2.be_addr_o); end
        @(posedge clk); #1;
        set_m2(1, 1'b0, 24'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (b2.m_ready_o !== 2'b01 || b2.be_addr_o !== 24'h200) begin
            errors++; $display("FAIL hold_next: ready %b addr %h want 01/200", b2.m_ready_o, b2.be_addr_o); end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0, a1;
        int exp;
        do_reset();
        b2.be_ready_i = 1'b1;
        for (int t = 0; t < 8; t++) begin
            a0 = AW'($urandom); a1 = AW'($urandom);
            set_m2(0, 1'b1, a0, $urandom, 4'h3);
            set_m2(1, 1'b1, a1, $urandom, 4'hC);
            exp = t % 2;
            @(negedge clk);
            checks++; if (b2.m_ready_o !== 2'(1 << exp) || b2.be_addr_o !== ((exp == 1) ? a1 : a0) || b2.m_rvalid_o !== 2'b00) begin
                errors++; $display("FAIL b2b[%0d]: ready %b addr %h rvalid %b want master %0d", t, b2.m_ready_o, b2.be_addr_o, b2.m_rvalid_o, exp); end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_reset_in_wait_r();
        do_reset();
        set_m2(0, 1'b1, 24'h30, 32'h0, 4'h0);
        b2.be_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (b2.m_ready_o !== 2'b01) begin errors++; $display("FAIL wr_rst_req: ready %b want 01", b2.m_ready_o); end
        @(posedge clk); #1;
        set_m2(0, 1'b0, 24'h0, 32'h0, 4'h0);
        set_m2(1, 1'b1, 24'h34, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (b2.be_valid_o !== 1'b0 || b2.m_ready_o !== 2'b00) begin
            errors++; $display("FAIL wait_r_quiet: valid %b ready %b want 0/00", b2.be_valid_o, b2.m_ready_o); end
        #1;
        rst_n = 1'b0;
        b2.be_rvalid_i = 1'b1;
        #1;
        checks++; if (b2.be_valid_o !== 1'b0 || b2.m_ready_o !== 2'b00 || b2.m_rvalid_o !== 2'b00) begin
            errors++; $display("FAIL in_reset: valid %b ready %b rvalid %b want all 0", b2.be_valid_o, b2.m_ready_o, b2.m_rvalid_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_m2(0, 1'b1, 24'h38, 32'h5, 4'hF);
        @(negedge clk);
        checks++; if (b2.m_rvalid_o !== 2'b00) begin errors++; $display("FAIL stray_rvalid: got %b want 00", b2.m_rvalid_o); end
        checks++; if (b2.m_ready_o !== 2'b01) begin errors++; $display("FAIL post_rst_grant: ready %b want 01", b2.m_ready_o); end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_wrap3();
        logic [2:0] masks [6] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b111, 3'b111};
        int         exps  [6] = '{0, 1, 2, 1, 2, 0};
        do_reset();
        b3.be_ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 3; k++)
                set_m3(k, masks[t][k], AW'(24'h500 + k * 4), 32'(k), 4'hF);
            @(negedge clk);
            checks++; if (b3.m_ready_o !== 3'(1 << exps[t]) || b3.be_addr_o !== AW'(24'h500 + exps[t] * 4)) begin
                errors++; $display("FAIL wrap3[%0d]: ready %b addr %h want master %0d", t, b3.m_ready_o, b3.be_addr_o, exps[t]); end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [1:0]    v;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [SW-1:0] s [2];
        logic          rdy, rv;
        logic [DW-1:0] rdat;
        int            c;
        logic          ev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [SW-1:0] es;
        logic [1:0]    er, erv;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 2; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                a[k] = AW'($urandom);
                d[k] = $urandom;
                s[k] = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
                set_m2(k, v[k], a[k], d[k], s[k]);
            end
            rdy  = ($urandom_range(0, 2) != 0);
            rv   = ($urandom_range(0, 1) == 1);
            rdat = $urandom;
            cke  = ($urandom_range(0, 9) != 0);
            b2.be_ready_i = rdy; b2.be_rvalid_i = rv; b2.be_rdata_i = rdat;

            if (rd_m >= 0)       c = -1;
            else if (lock_m >= 0) c = (((v >> lock_m) & 2'b01) != 0) ? lock_m : -1;
            else                 c = pick(v, nxt);
            ev  = (c >= 0);
            ea  = (c >= 0) ? a[c] : '0;
            ew  = (c >= 0) ? d[c] : '0;
            es  = (c >= 0) ? s[c] : '0;
            er  = (c >= 0 && rdy) ? 2'(1 << c) : 2'b00;
            erv = (rd_m >= 0 && rv) ? 2'(1 << rd_m) : 2'b00;

            @(negedge clk);
            checks++; if (b2.be_valid_o !== ev || b2.be_addr_o !== ea) begin
                errors++; $display("FAIL rnd_req[%0d]: valid %b addr %h want %b/%h", t, b2.be_valid_o, b2.be_addr_o, ev, ea); end
            checks++; if (b2.be_wdata_o !== ew || b2.be_wstrb_o !== es) begin
                errors++; $display("FAIL rnd_wr[%0d]: data %h strb %h want %h/%h", t, b2.be_wdata_o, b2.be_wstrb_o, ew, es); end
            checks++; if (b2.m_ready_o !== er) begin
                errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", t, b2.m_ready_o, er); end
            checks++; if (b2.m_rvalid_o !== erv || b2.m_rdata_o !== rdat) begin
                errors++; $display("FAIL rnd_rsp[%0d]: rvalid %b rdata %h want %b/%h", t, b2.m_rvalid_o, b2.m_rdata_o, erv, rdat); end

            if (cke) begin
                if (rd_m >= 0) begin
                    if (rv) begin nxt = (rd_m + 1) % 2; rd_m = -1; end
                end else if (c >= 0) begin
                    if (rdy) begin
                        if (s[c] != 0) nxt = (c + 1) % 2;
                        else           rd_m = c;
                        lock_m = -1;
                    end else begin
                        lock_m = c;
                    end
                end else begin
                    lock_m = -1;
                end
            end
            @(posedge clk); #1;
        end
        cke = 1'b1;
        drive_idle();
    endtask

    initial begin
        lock_m = -1;
        rd_m   = -1;
        nxt    = 0;
        drive_idle();
        test_reset();
        test_single_write_read();
        test_alternating_reads();
        test_hold();
        test_back_to_back();
        test_reset_in_wait_r();
        test_wrap3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
